// File: rtl/ap_sram_ctrl.sv
// 32-bit CPU bus to 256Kx16 async SRAM bridge: each request becomes up to two
// registered 16-bit SRAM cycles (low half, then high half) with WAIT_CYCLES strobe width.
module ap_sram_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        iCLK,
    input  logic        iRESET_n,
    input  logic        iREQ,
    input  logic        iRW,
    input  logic [31:0] iADDR,
    input  logic [31:0] iDATA,
    input  logic [3:0]  iBE,
    output logic [31:0] oDATA,
    output logic        oREADY,
    output logic        oBUSY,
    output logic [17:0] oSRAM_A,
    inout  wire  [15:0] ioSRAM_D,
    output logic        oSRAM_CE_n,
    output logic        oSRAM_OE_n,
    output logic        oSRAM_WE_n,
    output logic        oSRAM_UB_n,
    output logic        oSRAM_LB_n
);

    typedef enum logic [2:0] {IDLE, ACC_LO, REC_LO, ACC_HI, REC_HI, DONE} state_t;

    typedef struct packed {
        logic        rw;
        logic [16:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } req_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    req_t        rq;
    logic [3:0]  cnt;
    logic [31:0] rbuf;
    logic [15:0] d_out;
    logic        d_oe;
    logic        unused_addr;

    assign unused_addr = ^{iADDR[31:19], iADDR[1:0]};
    assign ioSRAM_D    = d_oe ? d_out : 16'bz;

    // Every pin is a flop: strobes for a state are loaded on the edge that enters it.
    always_ff @(posedge iCLK) begin
        if (!iRESET_n) begin
            state      <= IDLE;
            rq         <= '0;
            cnt        <= '0;
            rbuf       <= '0;
            oDATA      <= '0;
            oREADY     <= 1'b0;
            oBUSY      <= 1'b0;
            oSRAM_A    <= '0;
            oSRAM_CE_n <= 1'b1;
            oSRAM_OE_n <= 1'b1;
            oSRAM_WE_n <= 1'b1;
            oSRAM_UB_n <= 1'b1;
            oSRAM_LB_n <= 1'b1;
            d_out      <= '0;
            d_oe       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    oREADY <= 1'b0;
                    if (iREQ) begin
                        rq.rw   <= iRW;
                        rq.addr <= iADDR[18:2];
                        rq.data <= iDATA;
                        rq.be   <= iBE;
                        oBUSY   <= 1'b1;
                        cnt     <= CNT_INIT;
                        if (iRW || iBE[1:0] != 2'b00) begin
                            state      <= ACC_LO;
                            oSRAM_A    <= {iADDR[18:2], 1'b0};
                            oSRAM_CE_n <= 1'b0;
                            oSRAM_OE_n <= ~iRW;
                            oSRAM_WE_n <= iRW;
                            oSRAM_UB_n <= iRW ? 1'b0 : ~iBE[1];
                            oSRAM_LB_n <= iRW ? 1'b0 : ~iBE[0];
                            d_out      <= iDATA[15:0];
                            d_oe       <= ~iRW;
                        end else if (iBE[3:2] != 2'b00) begin
                            state      <= ACC_HI;
                            oSRAM_A    <= {iADDR[18:2], 1'b1};
                            oSRAM_CE_n <= 1'b0;
                            oSRAM_OE_n <= 1'b1;
                            oSRAM_WE_n <= 1'b0;
                            oSRAM_UB_n <= ~iBE[3];
                            oSRAM_LB_n <= ~iBE[2];
                            d_out      <= iDATA[31:16];
                            d_oe       <= 1'b1;
                        end else begin
                            state  <= DONE;
                            oREADY <= 1'b1;
                        end
                    end
                end
                ACC_LO, ACC_HI: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (rq.rw) begin
                            if (state == ACC_LO) rbuf[15:0]  <= ioSRAM_D;
                            else                 rbuf[31:16] <= ioSRAM_D;
                        end
                        state      <= (state == ACC_LO) ? REC_LO : REC_HI;
                        oSRAM_CE_n <= 1'b1;
                        oSRAM_OE_n <= 1'b1;
                        oSRAM_WE_n <= 1'b1;
                    end
                end
                REC_LO: begin
                    if (!rq.rw && rq.be[3:2] == 2'b00) begin
                        state      <= DONE;
                        oREADY     <= 1'b1;
                        oSRAM_UB_n <= 1'b1;
                        oSRAM_LB_n <= 1'b1;
                        d_oe       <= 1'b0;
                    end else begin
                        state      <= ACC_HI;
                        cnt        <= CNT_INIT;
                        oSRAM_A    <= {rq.addr, 1'b1};
                        oSRAM_CE_n <= 1'b0;
                        oSRAM_OE_n <= ~rq.rw;
                        oSRAM_WE_n <= rq.rw;
                        oSRAM_UB_n <= rq.rw ? 1'b0 : ~rq.be[3];
                        oSRAM_LB_n <= rq.rw ? 1'b0 : ~rq.be[2];
                        d_out      <= rq.data[31:16];
                    end
                end
                REC_HI: begin
                    state      <= DONE;
                    oREADY     <= 1'b1;
                    oSRAM_UB_n <= 1'b1;
                    oSRAM_LB_n <= 1'b1;
                    d_oe       <= 1'b0;
                    if (rq.rw) oDATA <= rbuf;
                end
                DONE: begin
                    state  <= IDLE;
                    oREADY <= 1'b0;
                    oBUSY  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ap_sram_ctrl.sv
// Random and directed requests against a word-level memory model; a pin-level
// SRAM model answers the controller and a monitor polices strobes and pin contents.
module tb_ap_sram_ctrl;

    localparam int WAIT = 2;

    logic        iCLK = 1'b0;
    logic        iRESET_n = 1'b0;
    logic        iREQ = 1'b0;
    logic        iRW = 1'b0;
    logic [31:0] iADDR = '0;
    logic [31:0] iDATA = '0;
    logic [3:0]  iBE = '0;
    logic [31:0] oDATA;
    logic        oREADY, oBUSY;
    logic [17:0] sram_a;
    wire  [15:0] sram_d;
    logic        ce_n, oe_n, we_n, ub_n, lb_n;

    ap_sram_ctrl #(.WAIT_CYCLES(WAIT)) dut (
        .iCLK(iCLK), .iRESET_n(iRESET_n), .iREQ(iREQ), .iRW(iRW),
        .iADDR(iADDR), .iDATA(iDATA), .iBE(iBE),
        .oDATA(oDATA), .oREADY(oREADY), .oBUSY(oBUSY),
        .oSRAM_A(sram_a), .ioSRAM_D(sram_d),
        .oSRAM_CE_n(ce_n), .oSRAM_OE_n(oe_n), .oSRAM_WE_n(we_n),
        .oSRAM_UB_n(ub_n), .oSRAM_LB_n(lb_n)
    );

    always #5 iCLK = ~iCLK;

    logic [15:0] smem [0:262143];
    logic [31:0] refm [0:131071];

    // pin-level async SRAM
    assign sram_d = (!ce_n && !oe_n) ? smem[sram_a] : 16'bz;
    always @(posedge iCLK) begin
        if (!ce_n && !we_n) begin
            if (!lb_n) smem[sram_a][7:0]  <= sram_d[7:0];
            if (!ub_n) smem[sram_a][15:8] <= sram_d[15:8];
        end
    end

    int          total = 0;
    int          bad = 0;
    int          viol = 0;
    int          pin_bad = 0;
    int          we_cyc = 0;
    int          oe_cyc = 0;
    logic [16:0] cur_word = '0;
    logic [3:0]  cur_be = '0;
    logic [31:0] cur_data = '0;
    logic [31:0] last_rd = '0;

    always @(negedge iCLK) begin
        if (!oe_n && !we_n) viol++;
        if ((!oe_n || !we_n) && ce_n) viol++;
        if (!we_n) we_cyc++;
        if (!oe_n) oe_cyc++;
        if (!ce_n && sram_a[17:1] != cur_word) pin_bad++;
        if (!ce_n && !oe_n && {ub_n, lb_n} != 2'b00) pin_bad++;
        if (!ce_n && !we_n) begin
            if ({ub_n, lb_n} != ~(sram_a[0] ? cur_be[3:2] : cur_be[1:0])) pin_bad++;
            if (sram_d != (sram_a[0] ? cur_data[31:16] : cur_data[15:0])) pin_bad++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int exp_lat(input logic rw, input logic [3:0] be);
        if (rw) return 2 * WAIT + 3;
        if (be == 4'h0) return 1;
        if (be[1:0] != 2'b00 && be[3:2] != 2'b00) return 2 * WAIT + 3;
        return WAIT + 2;
    endfunction

    task automatic do_req(input logic rw, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be, input bit poke);
        int          n, we0, oe0, halves;
        logic [16:0] w;
        w = a[18:2];
        cur_word = w;
        cur_be   = be;
        cur_data = d;
        halves = ((be[1:0] != 2'b00) ? 1 : 0) + ((be[3:2] != 2'b00) ? 1 : 0);
        we0 = we_cyc;
        oe0 = oe_cyc;
        iREQ = 1'b1; iRW = rw; iADDR = a; iDATA = d; iBE = be;
        @(posedge iCLK); #1;
        iREQ = 1'b0;
        n = 1;
        chk("busy", 32'(oBUSY), 32'd1);
        if (poke) begin
            iREQ = 1'b1; iRW = ~rw; iADDR = $urandom; iDATA = $urandom; iBE = 4'hF;
        end
        while (!oREADY && n < 64) begin
            @(posedge iCLK); #1;
            iREQ = 1'b0;
            n++;
        end
        iREQ = 1'b0;
        chk("lat", 32'(n), 32'(exp_lat(rw, be)));
        if (rw) begin
            chk("rdata", oDATA, refm[w]);
            last_rd = refm[w];
        end else begin
            for (int b = 0; b < 4; b++)
                if (be[b]) refm[w][8*b +: 8] = d[8*b +: 8];
            chk("hold", oDATA, last_rd);
        end
        @(posedge iCLK); #1;
        chk("idle", {30'd0, oBUSY, oREADY}, 32'd0);
        chk("we_cyc", 32'(we_cyc - we0), rw ? 32'd0 : 32'(WAIT * halves));
        chk("oe_cyc", 32'(oe_cyc - oe0), rw ? 32'(2 * WAIT) : 32'd0);
    endtask

    initial begin
        int          n;
        bit          rdy_seen;
        logic [31:0] a;
        logic [16:0] w;

        for (int i = 0; i < 262144; i++) smem[i] = '0;
        for (int i = 0; i < 131072; i++) refm[i] = '0;

        // reset
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_strb", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        chk("rst_flags", {30'd0, oBUSY, oREADY}, 32'd0);
        chk("rst_data", oDATA, 32'd0);
        chk("rst_addr", 32'(sram_a), 32'd0);
        iRESET_n = 1'b1;
        @(posedge iCLK); #1;

        // directed sequence
        do_req(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0);
        do_req(1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
        chk("t3_rd", oDATA, 32'hDEADBEEF);
        do_req(1'b0, 32'h10, 32'h00AA0000, 4'b0100, 1'b0);
        do_req(1'b1, 32'h10, 32'h0, 4'h0, 1'b0);
        chk("t4_rd", oDATA, 32'hDEAABEEF);
        do_req(1'b0, 32'h20, 32'h12345678, 4'h0, 1'b0);
        do_req(1'b0, 32'h14, 32'hCAFEF00D, 4'hF, 1'b1);
        do_req(1'b1, 32'h14, 32'h0, 4'h0, 1'b1);
        chk("t5_rd", oDATA, 32'hCAFEF00D);

        // reset while idle clears the read result
        iRESET_n = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("idle_rst_data", oDATA, 32'd0);
        chk("idle_rst_strb", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        chk("idle_rst_flags", {30'd0, oBUSY, oREADY}, 32'd0);
        iRESET_n = 1'b1;
        last_rd = '0;
        @(posedge iCLK); #1;

        // random traffic over a few low and high word addresses
        for (int t = 0; t < 150; t++) begin
            a = $urandom;
            w = ($urandom_range(0, 1) == 0) ? 17'($urandom_range(0, 7))
                                             : 17'h1FFF8 + 17'($urandom_range(0, 7));
            a[18:2] = w;
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0));
        end

        // abort a write during its high half; data equals what is already stored
        cur_word = 17'h4; cur_be = 4'hF; cur_data = refm[4];
        iREQ = 1'b1; iRW = 1'b0; iADDR = 32'h10; iDATA = refm[4]; iBE = 4'hF;
        @(posedge iCLK); #1;
        iREQ = 1'b0;
        n = 0;
        while (!(!we_n && sram_a[0]) && n < 20) begin
            @(posedge iCLK); #1;
            n++;
        end
        chk("abort_reach", 32'(n < 20), 32'd1);
        iRESET_n = 1'b0;
        @(posedge iCLK); #1;
        chk("abort_strb", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
        chk("abort_flags", {30'd0, oBUSY, oREADY}, 32'd0);
        iRESET_n = 1'b1;
        rdy_seen = 1'b0;
        repeat (8) begin
            @(posedge iCLK); #1;
            if (oREADY) rdy_seen = 1'b1;
        end
        chk("abort_nordy", 32'(rdy_seen), 32'd0);
        last_rd = '0;
        do_req(1'b1, 32'h10, 32'h0, 4'h0, 1'b0);

        chk("strobe_rules", 32'(viol), 32'd0);
        chk("pin_content", 32'(pin_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
